// File: rtl/riscv_regfile_pkg.sv
// Shared types and defaults for the multi-port register file and its destination delay line.
// Entry addresses are held at MAX_AW bits so one struct serves any NREG up to 2**MAX_AW.
package riscv_regfile_pkg;
  localparam int DEF_XLEN     = 32;
  localparam int DEF_NREG     = 32;
  localparam int MAX_WB_DELAY = 7;
  localparam int MAX_AW       = 8;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] addr;
  } dst_entry_t;
endpackage

// File: rtl/riscv_dst_delay.sv
// Shift register of destination entries; DEPTH cycles latency, never stalls (no backpressure).
// Head is the oldest stage, or the input itself when DEPTH is 0.
module riscv_dst_delay
  import riscv_regfile_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int SLOTS = (DEPTH > 0) ? DEPTH : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  dst_entry_t             dstIn,
  output dst_entry_t [SLOTS-1:0] stages,
  output dst_entry_t             head
);
  generate
    if (DEPTH == 0) begin : gNone
      assign stages = '0;
      assign head   = dstIn;
    end else begin : gPipe
      dst_entry_t [SLOTS-1:0] pipe;

      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          pipe <= '0;
        end else begin
          pipe[0] <= dstIn;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign stages = pipe;
      assign head   = pipe[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/riscv_regfile_mp.sv
// Register file with NUM_RD registered read ports (1 cycle, held while RdEn_i=0) and one write port
// whose destination is delayed WB_DELAY cycles to meet writeback data; no backpressure on writes.
module riscv_regfile_mp
  import riscv_regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREG     = DEF_NREG,
  parameter int AW       = $clog2(NREG),
  parameter int NUM_RD   = 2,
  parameter int WB_DELAY = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   RdEn_i,
  input  logic [NUM_RD*AW-1:0]   AddrR_i,
  output logic [NUM_RD*XLEN-1:0] DataR_o,
  output logic [NUM_RD-1:0]      Hazard_o,
  input  logic [AW-1:0]          AddrD_i,
  input  logic                   DstVal_i,
  input  logic [XLEN-1:0]        DataD_i,
  input  logic                   RegWEn_i,
  output logic                   WrErr_o
);
  localparam int SLOTS = (WB_DELAY > 0) ? WB_DELAY : 1;

  dst_entry_t             dstIn;
  dst_entry_t             head;
  dst_entry_t [SLOTS-1:0] stages;
  logic [XLEN-1:0]        regs [NREG];
  logic [NUM_RD*XLEN-1:0] rdNext;
  logic [NUM_RD-1:0]      hazNext;
  logic                   doWrite;
  logic                   wrKeep;

  assign dstIn = {DstVal_i, MAX_AW'(AddrD_i)};

  riscv_dst_delay #(.DEPTH(WB_DELAY)) uDelay (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .dstIn  (dstIn),
    .stages (stages),
    .head   (head)
  );

  assign doWrite = RegWEn_i && head.valid;
  assign wrKeep  = doWrite && !((ZERO_REG != 0) && (head.addr == '0));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      WrErr_o <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wrKeep && (head.addr == MAX_AW'(r))) regs[r] <= DataD_i;
      end
      if (RegWEn_i && !head.valid) WrErr_o <= 1'b1;
    end
  end

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : gPort
      logic [AW-1:0] ra;
      logic          isZero;
      logic          bypassHit;
      logic          inFlight;

      assign ra        = AddrR_i[p*AW +: AW];
      assign isZero    = (ZERO_REG != 0) && (ra == '0);
      assign bypassHit = (BYPASS != 0) && doWrite && (head.addr == MAX_AW'(ra));
      assign rdNext[p*XLEN +: XLEN] = isZero ? '0 : (bypassHit ? DataD_i : regs[ra]);

      // The stage retiring this cycle no longer counts as in flight.
      always_comb begin
        inFlight = DstVal_i && (AddrD_i == ra) && !((WB_DELAY == 0) && doWrite);
        for (int i = 0; i < WB_DELAY; i++) begin
          if (stages[i].valid && (stages[i].addr == MAX_AW'(ra)) &&
              !((i == WB_DELAY - 1) && doWrite))
            inFlight = 1'b1;
        end
      end

      assign hazNext[p] = inFlight && !isZero;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      DataR_o  <= '0;
      Hazard_o <= '0;
    end else if (RdEn_i) begin
      DataR_o  <= rdNext;
      Hazard_o <= hazNext;
    end
  end
endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Bench: two DUTs (bypass on/off) against a queue-based reference model with a decoupled scoreboard.
module tb_riscv_regfile_mp;
  localparam int XLEN = 32, NREG = 32, AW = 5, NUM_RD = 2, WB_DELAY = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic                   rst_i = 1'b0, RdEn_i = 1'b0, DstVal_i = 1'b0, RegWEn_i = 1'b0;
  logic [NUM_RD*AW-1:0]   AddrR_i = '0;
  logic [AW-1:0]          AddrD_i = '0;
  logic [XLEN-1:0]        DataD_i = '0;
  logic [NUM_RD*XLEN-1:0] DataR_o, DataRNb;
  logic [NUM_RD-1:0]      Hazard_o, HazardNb;
  logic                   WrErr_o, WrErrNb;

  riscv_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD), .WB_DELAY(WB_DELAY),
                     .BYPASS(1), .ZERO_REG(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .RdEn_i(RdEn_i), .AddrR_i(AddrR_i), .DataR_o(DataR_o),
    .Hazard_o(Hazard_o), .AddrD_i(AddrD_i), .DstVal_i(DstVal_i), .DataD_i(DataD_i),
    .RegWEn_i(RegWEn_i), .WrErr_o(WrErr_o));

  riscv_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD), .WB_DELAY(WB_DELAY),
                     .BYPASS(0), .ZERO_REG(1)) dutNb (
    .clk_i(clk_i), .rst_i(rst_i), .RdEn_i(RdEn_i), .AddrR_i(AddrR_i), .DataR_o(DataRNb),
    .Hazard_o(HazardNb), .AddrD_i(AddrD_i), .DstVal_i(DstVal_i), .DataD_i(DataD_i),
    .RegWEn_i(RegWEn_i), .WrErr_o(WrErrNb));

  typedef struct packed {
    logic [63:0] d;
    logic [63:0] dNb;
    logic [1:0]  h;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic       v;
    logic [4:0] a;
  } ent_t;

  logic [31:0] mem [NREG];
  ent_t        pend [$];
  exp_t        expQ [$];
  exp_t        last = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // One clock of stimulus; expectation comes from the architectural model before the edge.
  task automatic step(input logic rst, input logic rden, input logic [4:0] a0, input logic [4:0] a1,
                      input logic dv, input logic [4:0] ad, input logic wen, input logic [31:0] data);
    exp_t       e;
    logic       writing;
    logic [4:0] wa;
    logic [4:0] ra [2];
    rst_i = rst; RdEn_i = rden; AddrR_i = {a1, a0};
    DstVal_i = dv; AddrD_i = ad; RegWEn_i = wen; DataD_i = data;
    ra[0] = a0; ra[1] = a1;
    writing = wen && pend[0].v;
    wa = pend[0].a;
    if (!rst) begin
      e = '0;
    end else begin
      e = last;
      if (rden) begin
        for (int p = 0; p < 2; p++) begin
          logic h;
          h = dv && (ad == ra[p]);
          for (int i = 0; i < pend.size(); i++)
            if (pend[i].v && pend[i].a == ra[p] && !(i == 0 && writing)) h = 1'b1;
          if (ra[p] == 0) begin
            e.d[p*32 +: 32]   = '0;
            e.dNb[p*32 +: 32] = '0;
            e.h[p]            = 1'b0;
          end else begin
            e.d[p*32 +: 32]   = (writing && wa == ra[p]) ? data : mem[ra[p]];
            e.dNb[p*32 +: 32] = mem[ra[p]];
            e.h[p]            = h;
          end
        end
      end
      e.err = last.err | (wen && !pend[0].v);
    end
    expQ.push_back(e);
    last = e;
    @(posedge clk_i);
    if (!rst) begin
      foreach (mem[i]) mem[i] = '0;
      pend.delete();
      repeat (WB_DELAY) pend.push_back('0);
    end else begin
      if (writing && wa != 0) mem[wa] = data;
      void'(pend.pop_front());
      pend.push_back({dv, ad});
    end
    @(negedge clk_i);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
  endtask

  // Monitor: every registered output update is compared against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (expQ.size() > 0) begin
        exp_t x;
        x = expQ.pop_front();
        check("DataR_bypass", 64'(DataR_o), x.d);
        check("DataR_nobypass", 64'(DataRNb), x.dNb);
        check("Hazard", 64'(Hazard_o), 64'(x.h));
        check("WrErr", 64'(WrErr_o), 64'(x.err));
      end
    end
  end

  initial begin
    repeat (WB_DELAY) pend.push_back('0);
    foreach (mem[i]) mem[i] = '0;
    @(negedge clk_i);
    repeat (2) step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);

    // Freshly reset file reads all zero.
    for (int i = 1; i < 32; i++) step(1'b1, 1'b1, 5'(i), 5'(32 - i), 1'b0, 5'd0, 1'b0, 32'h0);

    // x5: hazard while in flight, same-cycle bypass, then settled value.
    step(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 32'h0);
    step(1'b1, 1'b1, 5'd5, 5'd1, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 1'b1, 32'hDEADBEEF);
    step(1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 32'h0);

    // x0 ignores writes and never flags.
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h12345678);
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);

    // x7 old value, then a write while reads are stalled.
    step(1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 32'h0);
    idle(); idle();
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h11111111);
    step(1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 32'h0);
    step(1'b1, 1'b1, 5'd7, 5'd3, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b1, 32'h77777777);
    step(1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 32'h0);

    // Write enable with nothing in flight right after reset: sticky error, no register change.
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 5'd5, 5'd7, 1'b0, 5'd0, 1'b1, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 5'd5, 5'd7, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 5'd5, 5'd7, 1'b0, 5'd0, 1'b0, 32'h0);

    // Random traffic over a few hot registers, with occasional mid-run resets.
    for (int n = 0; n < 600; n++) begin
      logic rst, wen;
      rst = ($urandom_range(0, 99) != 0);
      wen = pend[0].v ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 39) == 0);
      step(rst, ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), wen, $urandom);
    end

    repeat (2) @(negedge clk_i);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
